// File: rtl/gost_ctr_gamma.sv
// gost_ctr_gamma: GOST 28147-89 counter-mode (gamma) sequencer driving an external cipher core.
module gost_ctr_gamma #(
   parameter int CORE_LAT = 33
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        init,
   input  logic [63:0] iv,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [63:0] in_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [63:0] out_data,
   output logic        core_load,
   output logic        core_mode,
   output logic [63:0] core_pdata,
   input  logic        core_done,
   input  logic [63:0] core_cdata,
   output logic        busy,
   output logic        err
);
   localparam logic [5:0] LAT = 6'(CORE_LAT);
   typedef enum logic [2:0] {IDLE, LOAD_IV, WAIT_IV, READY, LOAD, WAIT, OUT} state_t;
   state_t      state;
   logic [31:0] s_lo, s_hi, lo_n, hi_n;
   logic [63:0] hold;
   logic [5:0]  cnt;
   logic        synced;
   logic [32:0] t;
   // N4 uses addition mod 2^32-1 with end-around carry; 0xFFFFFFFF is kept as-is
   assign t = {1'b0, s_hi} + 33'h0_01010104;
   assign hi_n = t[31:0] + {31'b0, t[32]};
   assign lo_n = s_lo + 32'h01010101;
   assign core_mode = 1'b0;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state <= IDLE;
         s_lo <= '0;
         s_hi <= '0;
         hold <= '0;
         cnt <= '0;
         synced <= 1'b0;
         in_ready <= 1'b0;
         out_valid <= 1'b0;
         out_data <= '0;
         core_load <= 1'b0;
         core_pdata <= '0;
         busy <= 1'b0;
         err <= 1'b0;
      end else if (init) begin
         state <= LOAD_IV;
         core_load <= 1'b1;
         core_pdata <= iv;
         synced <= 1'b0;
         in_ready <= 1'b0;
         out_valid <= 1'b0;
         err <= 1'b0;
         busy <= 1'b1;
      end else
         case (state)
            LOAD_IV, LOAD: begin
               core_load <= 1'b0;
               cnt <= 6'd1;
               state <= state == LOAD_IV ? WAIT_IV : WAIT;
            end
            WAIT_IV: if (cnt == LAT) begin
               busy <= 1'b0;
               if (core_done) begin
                  {s_hi, s_lo} <= core_cdata;
                  synced <= 1'b1;
                  in_ready <= 1'b1;
                  state <= READY;
               end else begin
                  err <= 1'b1;
                  state <= IDLE;
               end
            end else
               cnt <= cnt + 6'd1;
            READY: if (in_valid && synced) begin
               hold <= in_data;
               s_lo <= lo_n;
               s_hi <= hi_n;
               core_load <= 1'b1;
               core_pdata <= {hi_n, lo_n};
               in_ready <= 1'b0;
               busy <= 1'b1;
               state <= LOAD;
            end
            WAIT: if (cnt == LAT) begin
               if (core_done) begin
                  out_data <= hold ^ core_cdata;
                  out_valid <= 1'b1;
                  state <= OUT;
               end else begin
                  err <= 1'b1;
                  busy <= 1'b0;
                  state <= IDLE;
               end
            end else
               cnt <= cnt + 6'd1;
            OUT: if (out_ready) begin
               out_valid <= 1'b0;
               in_ready <= 1'b1;
               busy <= 1'b0;
               state <= READY;
            end
            default: state <= IDLE;
         endcase
endmodule

// File: tb/tb_gost_ctr_gamma.sv
// tb_gost_ctr_gamma: bench for gost_ctr_gamma with an inverting core stub and a scoreboard.
module tb_gost_ctr_gamma;
   localparam int LAT = 33;
   logic        clk = 0, rst_n = 0, init = 0, in_valid = 0, out_ready = 1;
   logic [63:0] iv = '0, in_data = '0;
   logic        in_ready, out_valid, core_load, core_mode, core_done, busy, err;
   logic [63:0] out_data, core_pdata, core_cdata;
   int          checks = 0, errors = 0, loads = 0, l0;
   logic [63:0] exp_q[$];
   logic [31:0] m_lo, m_hi;
   logic [63:0] d;
   bit          suppress = 0;
   logic        st_act = 0;
   logic [5:0]  st_cnt = '0;
   logic [63:0] st_data = '0;

   gost_ctr_gamma #(.CORE_LAT(LAT)) dut (
      .clk(clk), .rst_n(rst_n), .init(init), .iv(iv),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .core_load(core_load), .core_mode(core_mode), .core_pdata(core_pdata),
      .core_done(core_done), .core_cdata(core_cdata), .busy(busy), .err(err)
   );

   always #5 clk = ~clk;

   // core stub: result ~pdata LAT cycles after load, plus a junk done one cycle after load
   always @(posedge clk)
      if (core_load) begin
         st_act <= 1'b1;
         st_cnt <= 6'd1;
         st_data <= ~core_pdata;
      end else if (st_act) begin
         st_cnt <= st_cnt + 6'd1;
         if (st_cnt == 6'(LAT)) st_act <= 1'b0;
      end
   assign core_done = st_act && (st_cnt == 6'd1 || (st_cnt == 6'(LAT) && !suppress));
   assign core_cdata = (st_act && st_cnt == 6'(LAT)) ? st_data : 64'h0123_4567_89AB_CDEF;

   task automatic chk(string name, logic [63:0] act, logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, req);
      end
   endtask

   function automatic logic [31:0] madd(logic [31:0] a);
      logic [32:0] s;
      s = {1'b0, a} + 33'h0_01010104;
      return s >= 33'h1_0000_0000 ? 32'(s - 33'h0_FFFF_FFFF) : s[31:0];
   endfunction

   always @(negedge clk) begin
      loads += int'(core_load);
      if (out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL stray_out: out_data %h with no word pending", out_data);
         end else
            chk("scoreboard", out_data, exp_q.pop_front());
      end
   end

   task automatic tick(int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_init(logic [63:0] v);
      int k;
      init = 1;
      iv = v;
      exp_q.delete();
      tick();
      init = 0;
      chk("init_load", {63'b0, core_load}, 64'd1);
      chk("init_pdata", core_pdata, v);
      chk("init_clears", {61'b0, err, out_valid, in_ready}, 64'd0);
      k = 1;
      while (!in_ready && k < 100) begin
         tick();
         k++;
      end
      chk("init_to_ready", 64'(k), 64'(LAT + 2));
      {m_hi, m_lo} = ~v;
   endtask

   task automatic send(logic [63:0] x);
      int k = 0;
      while (!in_ready && k < 200) begin
         tick();
         k++;
      end
      if (!in_ready) chk("in_ready_timeout", {63'b0, in_ready}, 64'd1);
      in_valid = 1;
      in_data = x;
      m_lo = m_lo + 32'h01010101;
      m_hi = madd(m_hi);
      exp_q.push_back(x ^ ~{m_hi, m_lo});
      tick();
      in_valid = 0;
      chk("load_after_hs", {62'b0, core_load, in_ready}, 64'd2);
   endtask

   task automatic wait_out(output logic [63:0] r);
      int k = 1;
      while (!out_valid && k < 100) begin
         tick();
         k++;
      end
      chk("hs_to_out_valid", 64'(k), 64'(LAT + 2));
      r = out_data;
   endtask

   typedef struct {logic [63:0] din; logic [63:0] exp;} vec_t;
   vec_t tbl[3];

   initial begin
      tbl[0] = '{64'h0, 64'hFEFEFEFB_FEFEFEFF};
      tbl[1] = '{64'h0, 64'hFDFDFDF7_FDFDFDFE};
      tbl[2] = '{64'hFFFFFFFF_FFFFFFFF, 64'h0303030C_03030302};
      tick(2);
      chk("rst_ctrl", {58'b0, out_valid, in_ready, core_load, core_mode, busy, err}, 64'd0);
      chk("rst_out_data", out_data, 64'd0);
      chk("rst_pdata", core_pdata, 64'd0);
      rst_n = 1;
      tick(3);
      chk("idle_quiet", {61'b0, in_ready, busy, core_load}, 64'd0);
      do_init(64'd0);
      chk("ready_not_busy", {63'b0, busy}, 64'd0);
      for (int i = 0; i < 3; i++) begin
         send(tbl[i].din);
         wait_out(d);
         chk($sformatf("tbl_out%0d", i), d, tbl[i].exp);
      end
      tick(2);
      do_init(64'h01010104_FFFFFFFF);
      send(64'd0);
      wait_out(d);
      chk("edge_hi", {32'b0, d[63:32]}, 64'd0);
      chk("edge_full", d, 64'h00000000_FEFEFEFE);
      tick(2);
      out_ready = 0;
      l0 = loads;
      send(64'h1234_5678_9ABC_DEF0);
      wait_out(d);
      for (int i = 0; i < 10; i++) begin
         tick();
         chk("bp_stable", out_data, d);
         chk("bp_flags", {62'b0, out_valid, in_ready}, 64'd2);
      end
      chk("bp_one_load", 64'(loads - l0), 64'd1);
      out_ready = 1;
      tick();
      chk("bp_release", {62'b0, out_valid, in_ready}, 64'd1);
      suppress = 1;
      send(64'hA5A5_A5A5_5A5A_5A5A);
      begin
         int k = 1;
         while (!err && k < 100) begin
            tick();
            k++;
         end
         chk("err_time", 64'(k), 64'(LAT + 2));
      end
      chk("err_state", {59'b0, err, busy, in_ready, out_valid, core_load}, 64'h10);
      exp_q.delete();
      suppress = 0;
      tick(5);
      chk("err_sticky", {63'b0, err}, 64'd1);
      do_init(64'h0123_4567_89AB_CDEF);
      send(64'h5555_AAAA_0F0F_F0F0);
      wait_out(d);
      tick(2);
      send(64'hDEAD_BEEF_0000_FFFF);
      tick(10);
      chk("abort_busy", {63'b0, busy}, 64'd1);
      do_init(64'hCAFE_F00D_1357_9BDF);
      send(64'h0F1E_2D3C_4B5A_6978);
      wait_out(d);
      tick(2);
      out_ready = 0;
      send(64'h7777_8888_9999_AAAA);
      wait_out(d);
      rst_n = 0;
      exp_q.delete();
      tick();
      chk("rst2_ctrl", {58'b0, out_valid, in_ready, core_load, core_mode, busy, err}, 64'd0);
      chk("rst2_out_data", out_data, 64'd0);
      rst_n = 1;
      tick(40);
      chk("rst2_idle", {60'b0, out_valid, in_ready, busy, err}, 64'd0);
      out_ready = 1;
      tick(2);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: bench did not complete, %0d checks so far", checks);
      $fatal(1);
   end
endmodule
